// File: rtl/fill_arbiter.sv
// Merges dirty fills and clean refills into single-beat AXI writes of tag+data line words,
// round-robin arbitrated and throttled by an outstanding-B credit count.
module fill_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int INDEX_WIDTH     = 10,
   parameter int OFFSET_WIDTH    = 6,
   parameter int TAG_WIDTH       = 16,
   parameter int BLANK_WIDTH     = 4,
   parameter int TAG_SIZE        = 2 + TAG_WIDTH + BLANK_WIDTH,
   parameter int FILL_ID         = 0,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           fill_valid_i,
   output logic                           fill_ready_o,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
   input  logic                           refill_valid_i,
   output logic                           refill_ready_o,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
   output logic [ID_WIDTH-1:0]            awid_o,
   output logic [ADDR_WIDTH-1:0]          awaddr_o,
   output logic [7:0]                     awlen_o,
   output logic                           awvalid_o,
   input  logic                           awready_i,
   output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
   output logic                           wlast_o,
   output logic                           wvalid_o,
   input  logic                           wready_i,
   input  logic [ID_WIDTH-1:0]            bid_i,
   input  logic [1:0]                     bresp_i,
   input  logic                           bvalid_i,
   output logic                           bready_o,
   output logic                           err_o,
   output logic                           busy_o
);

   localparam int LINE_W = TAG_SIZE + DATA_WIDTH;
   localparam int LOW_W  = INDEX_WIDTH + OFFSET_WIDTH;
   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

   state_t                state_q, state_d;
   logic [3:0]            outstanding_q, outstanding_d;
   logic                  last_fill_q, last_fill_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [LINE_W-1:0]     wdata_q, wdata_d;

   logic                  idle, credit, b_live;
   logic                  fill_win, refill_win, fill_grant, grant;
   logic                  aw_hs, w_hs;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] sel_data;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  unused_bid;

   assign unused_bid = ^bid_i;

   assign idle   = (state_q == S_IDLE);
   // A B arriving this cycle frees its slot immediately, so a grant may share the cycle.
   assign b_live = bvalid_i && (outstanding_q != 4'd0);
   assign credit = (outstanding_q < MAX_CNT) || b_live;

   // last_fill_q high means fill won the previous grant, so refill wins the next tie.
   assign fill_win   = fill_valid_i && (!refill_valid_i || !last_fill_q);
   assign refill_win = refill_valid_i && (!fill_valid_i || last_fill_q);

   assign fill_ready_o   = idle && credit && fill_win;
   assign refill_ready_o = idle && credit && refill_win;

   assign fill_grant = fill_ready_o;
   assign grant      = fill_ready_o || refill_ready_o;
   assign sel_data   = fill_grant ? fill_data_i : refill_data_i;
   assign sel_addr   = sel_data[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];

   assign aw_hs = awvalid_q && awready_i;
   assign w_hs  = wvalid_q && wready_i;

   always_comb begin
      state_d     = state_q;
      last_fill_d = last_fill_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (grant) begin
               state_d     = S_SEND;
               last_fill_d = fill_grant;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               awvalid_d   = 1'b1;
               wvalid_d    = 1'b1;
               awaddr_d    = {{TAG_WIDTH{1'b0}}, sel_addr[LOW_W-1:0]};
               wdata_d     = {1'b1, fill_grant, sel_addr[ADDR_WIDTH-1 -: TAG_WIDTH],
                              {BLANK_WIDTH{1'b0}}, sel_data[DATA_WIDTH-1:0]};
            end
         end
         S_SEND: begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
            awvalid_d = !aw_done_d;
            wvalid_d  = !w_done_d;
            if (aw_done_d && w_done_d) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      outstanding_d = outstanding_q;
      case ({grant, b_live})
         2'b10:   outstanding_d = outstanding_q + 4'd1;
         2'b01:   outstanding_d = outstanding_q - 4'd1;
         default: outstanding_d = outstanding_q;
      endcase
      // A B with nothing outstanding is a protocol error, as is any non-OKAY response.
      err_d = err_q || (bvalid_i && ((bresp_i != 2'b00) || (outstanding_q == 4'd0)));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         outstanding_q <= 4'd0;
         last_fill_q   <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         err_q         <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         last_fill_q   <= last_fill_d;
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         err_q         <= err_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
      end
   end

   assign awid_o    = ID_WIDTH'(FILL_ID);
   assign awaddr_o  = awaddr_q;
   assign awlen_o   = 8'd0;
   assign awvalid_o = awvalid_q;
   assign wdata_o   = wdata_q;
   assign wlast_o   = 1'b1;
   assign wvalid_o  = wvalid_q;
   assign bready_o  = 1'b1;
   assign err_o     = err_q;
   assign busy_o    = (state_q != S_IDLE) || (outstanding_q != 4'd0);

endmodule

// File: tb/tb_fill_arbiter.sv
// Directed bench for fill_arbiter: reset values, word build, round-robin, W stall,
// credit limit, error stickiness and reset during a send.
module tb_fill_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 22 + DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fill_valid_i, fill_ready_o;
   logic [AW+DW-1:0] fill_data_i;
   logic          refill_valid_i, refill_ready_o;
   logic [AW+DW-1:0] refill_data_i;
   logic [3:0]    awid_o;
   logic [AW-1:0] awaddr_o;
   logic [7:0]    awlen_o;
   logic          awvalid_o, awready_i;
   logic [LW-1:0] wdata_o;
   logic          wlast_o, wvalid_o, wready_i;
   logic [3:0]    bid_i;
   logic [1:0]    bresp_i;
   logic          bvalid_i, bready_o, err_o, busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   fill_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data_i),
      .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o), .refill_data_i(refill_data_i),
      .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
      .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
      .err_o(err_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fill_valid_i = 1'b0; refill_valid_i = 1'b0;
      fill_data_i = '0; refill_data_i = '0;
      awready_i = 1'b1; wready_i = 1'b1;
      bvalid_i = 1'b0; bresp_i = 2'b00; bid_i = 4'd0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic do_fill(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      fill_valid_i = 1'b1;
      fill_data_i  = {addr, data};
      tick();
      fill_valid_i = 1'b0;
      tick();
      tick();
      $display("txn: fill addr=%h data=%h sent", addr, data);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (awvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_awvalid: got %0b want 0", awvalid_o); end
      n_cmp++; if (wvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid: got %0b want 0", wvalid_o); end
      n_cmp++; if (awid_o !== 4'd0) begin n_bad++; $display("FAIL reset_awid: got %h want 0", awid_o); end
      n_cmp++; if (awaddr_o !== 32'd0) begin n_bad++; $display("FAIL reset_awaddr: got %h want 0", awaddr_o); end
      n_cmp++; if (wdata_o !== '0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
      n_cmp++; if (awlen_o !== 8'd0) begin n_bad++; $display("FAIL reset_awlen: got %h want 0", awlen_o); end
      n_cmp++; if (wlast_o !== 1'b1) begin n_bad++; $display("FAIL reset_wlast: got %0b want 1", wlast_o); end
      n_cmp++; if (bready_o !== 1'b1) begin n_bad++; $display("FAIL reset_bready: got %0b want 1", bready_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
      $display("txn: reset checked");
   endtask

   task automatic test_single_fill();
      do_reset();
      fill_valid_i = 1'b1;
      fill_data_i  = {32'hABCD_1240, 32'hA5A5_5A5A};
      #1;
      n_cmp++; if (fill_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_fill_ready: got %0b want 1", fill_ready_o); end
      n_cmp++; if (refill_ready_o !== 1'b0) begin n_bad++; $display("FAIL single_refill_ready: got %0b want 0", refill_ready_o); end
      tick();
      fill_valid_i = 1'b0;
      #1;
      n_cmp++; if (awvalid_o !== 1'b1) begin n_bad++; $display("FAIL single_awvalid: got %0b want 1", awvalid_o); end
      n_cmp++; if (wvalid_o !== 1'b1) begin n_bad++; $display("FAIL single_wvalid: got %0b want 1", wvalid_o); end
      n_cmp++; if (awaddr_o !== 32'h0000_1240) begin n_bad++; $display("FAIL single_awaddr: got %h want 00001240", awaddr_o); end
      n_cmp++; if (wdata_o !== {2'b11, 16'hABCD, 4'h0, 32'hA5A5_5A5A}) begin n_bad++; $display("FAIL single_wdata: got %h want %h", wdata_o, {2'b11, 16'hABCD, 4'h0, 32'hA5A5_5A5A}); end
      n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy_send: got %0b want 1", busy_o); end
      tick();
      n_cmp++; if (awvalid_o !== 1'b0 || wvalid_o !== 1'b0) begin n_bad++; $display("FAIL single_done: got aw=%0b w=%0b want 0 0", awvalid_o, wvalid_o); end
      n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy_wait_b: got %0b want 1", busy_o); end
      bvalid_i = 1'b1;
      tick();
      bvalid_i = 1'b0;
      #1;
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_busy_after_b: got %0b want 0", busy_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL single_err: got %0b want 0", err_o); end
      $display("txn: single fill ABCD1240 done");
   endtask

   task automatic test_round_robin();
      logic exp_fill;
      do_reset();
      fill_valid_i   = 1'b1; fill_data_i   = {32'h1111_2040, 32'hF0F0_0001};
      refill_valid_i = 1'b1; refill_data_i = {32'h2222_3080, 32'h0E0E_0002};
      for (int i = 0; i < 4; i++) begin
         exp_fill = ((i % 2) == 0);
         #1;
         n_cmp++; if (fill_ready_o !== exp_fill || refill_ready_o !== !exp_fill) begin n_bad++; $display("FAIL rr_grant%0d: got fill=%0b refill=%0b want fill=%0b", i, fill_ready_o, refill_ready_o, exp_fill); end
         tick();
         if (exp_fill) begin
            n_cmp++; if (wdata_o !== {2'b11, 16'h1111, 4'h0, 32'hF0F0_0001}) begin n_bad++; $display("FAIL rr_word%0d: got %h want fill word", i, wdata_o); end
            n_cmp++; if (awaddr_o !== 32'h0000_2040) begin n_bad++; $display("FAIL rr_addr%0d: got %h want 00002040", i, awaddr_o); end
         end else begin
            n_cmp++; if (wdata_o !== {2'b10, 16'h2222, 4'h0, 32'h0E0E_0002}) begin n_bad++; $display("FAIL rr_word%0d: got %h want refill word", i, wdata_o); end
            n_cmp++; if (awaddr_o !== 32'h0000_3080) begin n_bad++; $display("FAIL rr_addr%0d: got %h want 00003080", i, awaddr_o); end
         end
         $display("txn: rr grant %0d to %s", i, exp_fill ? "fill" : "refill");
         tick();
      end
      fill_valid_i = 1'b0; refill_valid_i = 1'b0;
   endtask

   task automatic test_w_stall();
      do_reset();
      wready_i = 1'b0;
      fill_valid_i = 1'b1; fill_data_i = {32'h0000_5A40, 32'h1234_5678};
      #1;
      n_cmp++; if (fill_ready_o !== 1'b1) begin n_bad++; $display("FAIL stall_grant: got %0b want 1", fill_ready_o); end
      tick();
      fill_valid_i = 1'b0;
      refill_valid_i = 1'b1; refill_data_i = {32'h3333_0040, 32'hDEAD_BEEF};
      #1;
      n_cmp++; if (awvalid_o !== 1'b1 || wvalid_o !== 1'b1) begin n_bad++; $display("FAIL stall_valids: got aw=%0b w=%0b want 1 1", awvalid_o, wvalid_o); end
      tick();
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++; if (awvalid_o !== 1'b0 || wvalid_o !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d: got aw=%0b w=%0b want 0 1", c, awvalid_o, wvalid_o); end
         n_cmp++; if (wdata_o !== {2'b11, 16'h0000, 4'h0, 32'h1234_5678}) begin n_bad++; $display("FAIL stall_wdata%0d: got %h want stable word", c, wdata_o); end
         n_cmp++; if (refill_ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_noready%0d: got %0b want 0", c, refill_ready_o); end
         tick();
      end
      wready_i = 1'b1;
      #1;
      n_cmp++; if (wvalid_o !== 1'b1 || refill_ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_last: got w=%0b rr=%0b want 1 0", wvalid_o, refill_ready_o); end
      tick();
      n_cmp++; if (wvalid_o !== 1'b0 || refill_ready_o !== 1'b1) begin n_bad++; $display("FAIL stall_release: got w=%0b rr=%0b want 0 1", wvalid_o, refill_ready_o); end
      refill_valid_i = 1'b0;
      $display("txn: W stall released");
   endtask

   task automatic test_credit();
      int grants;
      do_reset();
      fill_valid_i = 1'b1; fill_data_i = {32'h4444_0100, 32'h0000_00C1};
      grants = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (fill_ready_o) grants++;
         tick();
      end
      n_cmp++; if (grants !== 4) begin n_bad++; $display("FAIL credit_fill_to_max: got %0d grants want 4", grants); end
      n_cmp++; if (fill_ready_o !== 1'b0) begin n_bad++; $display("FAIL credit_exhausted: got %0b want 0", fill_ready_o); end
      bvalid_i = 1'b1;
      #1;
      n_cmp++; if (fill_ready_o !== 1'b1) begin n_bad++; $display("FAIL credit_b_same_cycle: got %0b want 1", fill_ready_o); end
      tick();
      bvalid_i = 1'b0;
      tick();
      n_cmp++; if (fill_ready_o !== 1'b0) begin n_bad++; $display("FAIL credit_still_max: got %0b want 0", fill_ready_o); end
      grants = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (fill_ready_o) grants++;
         tick();
      end
      n_cmp++; if (grants !== 0) begin n_bad++; $display("FAIL credit_no_extra: got %0d grants want 0", grants); end
      fill_valid_i = 1'b0;
      bvalid_i = 1'b1;
      tick();
      bvalid_i = 1'b0;
      fill_valid_i = 1'b1;
      grants = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (fill_ready_o) grants++;
         tick();
      end
      n_cmp++; if (grants !== 1) begin n_bad++; $display("FAIL credit_one_more: got %0d grants want 1", grants); end
      n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL credit_busy: got %0b want 1", busy_o); end
      fill_valid_i = 1'b0;
      $display("txn: credit limit exercised");
   endtask

   task automatic test_err();
      do_reset();
      do_fill(32'h5555_0200, 32'h0000_0E01);
      bvalid_i = 1'b1; bresp_i = 2'b00;
      tick();
      bvalid_i = 1'b0;
      #1;
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_okay_b: got %0b want 0", err_o); end
      do_fill(32'h5555_0240, 32'h0000_0E02);
      bvalid_i = 1'b1; bresp_i = 2'b10;
      #1;
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_not_yet: got %0b want 0", err_o); end
      tick();
      bvalid_i = 1'b0; bresp_i = 2'b00;
      #1;
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_rise: got %0b want 1", err_o); end
      tick(); tick(); tick();
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b want 1", err_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL err_busy: got %0b want 0", busy_o); end
      do_reset();
      n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %0b want 0", err_o); end
      bvalid_i = 1'b1;
      tick();
      bvalid_i = 1'b0;
      #1;
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_stray_b: got %0b want 1", err_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL err_stray_saturate: got %0b want 0", busy_o); end
      $display("txn: error responses checked");
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      awready_i = 1'b0; wready_i = 1'b0;
      fill_valid_i = 1'b1; fill_data_i = {32'h6666_0300, 32'h0000_0F01};
      tick();
      fill_valid_i = 1'b0;
      #1;
      n_cmp++; if (awvalid_o !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got %0b want 1", awvalid_o); end
      rst_n = 1'b0;
      tick();
      n_cmp++; if (awvalid_o !== 1'b0 || wvalid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valids: got aw=%0b w=%0b want 0 0", awvalid_o, wvalid_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0b want 0", busy_o); end
      rst_n = 1'b1;
      awready_i = 1'b1; wready_i = 1'b1;
      tick();
      n_cmp++; if (awvalid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_discard: got aw=%0b busy=%0b want 0 0", awvalid_o, busy_o); end
      $display("txn: reset during send discarded transaction");
   endtask

   initial begin
      rst_n = 1'b0;
      fill_valid_i = 1'b0; refill_valid_i = 1'b0;
      fill_data_i = '0; refill_data_i = '0;
      awready_i = 1'b1; wready_i = 1'b1;
      bvalid_i = 1'b0; bresp_i = 2'b00; bid_i = 4'd0;
      @(negedge clk);
      test_reset();
      test_single_fill();
      test_round_robin();
      test_w_stall();
      test_credit();
      test_err();
      test_reset_mid_send();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fill_arbiter.md
# fill_arbiter

Merges the two DRAM-cache fill sources into one AXI write stream toward the memory controller: write-hit/write-miss fills from the tag comparator (dirty) and read-miss refills from the miss-return path (clean). For each accepted fill it builds the tag+data line word (valid, dirty, tag, blank, data) and issues a single-beat AW/W pair. It tracks B responses against an outstanding-write credit limit. The block is the consumer on the comparator's fill valid/ready interface and the write initiator on the cache-side memory controller port.

## Interface
- ADDR_WIDTH, `AXI_ADDR_WIDTH, request/cache address width
- DATA_WIDTH, `AXI_DATA_WIDTH, line data width
- ID_WIDTH, `AXI_ID_WIDTH, AXI ID width
- TAG_SIZE, `TAG_SIZE, tag field width; TAG_SIZE = 2 + TAG_WIDTH + BLANK_WIDTH
- TAG_WIDTH / BLANK_WIDTH, `TAG_WIDTH / `BLANK_WIDTH, tag bits / zero padding
- INDEX_WIDTH / OFFSET_WIDTH, `INDEX_WIDTH / `OFFSET_WIDTH, set-index / offset bits
- FILL_ID, 0, constant awid
- MAX_OUTSTANDING, 4, max writes awaiting B (1..15)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- fill_valid_i / fill_ready_o  in/out  1  comparator fill handshake (dirty=1)
- fill_data_i  in  ADDR_WIDTH+DATA_WIDTH  {addr, data}
- refill_valid_i / refill_ready_o  in/out  1  miss-return handshake (dirty=0)
- refill_data_i  in  ADDR_WIDTH+DATA_WIDTH  {addr, data}
- awid_o  out  ID_WIDTH;  awaddr_o  out  ADDR_WIDTH;  awlen_o  out  8 (always 0)
- awvalid_o / awready_i  out/in  1
- wdata_o  out  TAG_SIZE+DATA_WIDTH;  wlast_o  out  1 (always 1)
- wvalid_o / wready_i  out/in  1
- bid_i  in  ID_WIDTH;  bresp_i  in  2;  bvalid_i  in  1;  bready_o  out  1 (always 1)
- err_o  out  1  sticky: some B had bresp != 2'b00
- busy_o  out  1  state != S_IDLE or outstanding != 0

## Operation
- States: S_IDLE, S_SEND.
- S_IDLE: credit = (outstanding < MAX_OUTSTANDING). Ready is combinational. Only the arbitration winner sees ready; ready = win & credit.
- Arbitration is round-robin. On a tie, the source not granted last wins. last_grant resets to refill, so the first tie goes to fill.
- Grant (valid & ready):
  - Capture addr, data, dirty.
  - outstanding += 1.
  - Clear aw_done / w_done.
  - Go to S_SEND.
- Word build: wdata[TOP] = 1 (valid), wdata[TOP-1] = dirty, next TAG_WIDTH bits = addr[ADDR_WIDTH-1 : INDEX_WIDTH+OFFSET_WIDTH], next BLANK_WIDTH bits = 0, wdata[DATA_WIDTH-1:0] = data. TOP = TAG_SIZE+DATA_WIDTH-1.
- awaddr = addr with tag bits [ADDR_WIDTH-1 : INDEX_WIDTH+OFFSET_WIDTH] zeroed (set-index address).
- S_SEND:
  - awvalid = !aw_done; wvalid = !w_done. AW and W are independent and may complete in either order or in the same cycle.
  - Set aw_done on awvalid & awready; set w_done on wvalid & wready.
  - Go to S_IDLE in the cycle where both are done, counting same-cycle handshakes.
  - Both ready inputs are 0 in S_SEND.
- B channel:
  - bvalid_i decrements outstanding.
  - A grant and a B in the same cycle leave outstanding unchanged.
  - bid_i is ignored.
  - bresp_i != 0 sets err_o, which clears only on reset.
  - A B with outstanding == 0 is ignored (saturates at 0) and sets err_o.
- AW/W payloads stay stable while their valid is high. valid never drops before its handshake.

## Timing
- Reset: state S_IDLE, outstanding 0, last_grant refill, awvalid_o/wvalid_o 0, awid_o FILL_ID, awaddr_o 0, wdata_o 0, awlen_o 0, wlast_o 1, bready_o 1, err_o 0, busy_o 0.
- A reset asserted mid-S_SEND drops valids on the next edge; the captured transaction is discarded.
- Grant at edge T: awvalid_o/wvalid_o high from T+1. With awready/wready held at 1, back in S_IDLE at T+2. Peak throughput: 1 fill per 2 cycles.
- Credit exhausted (outstanding == MAX_OUTSTANDING): both readys stay 0 until a B arrives. A grant may occur in the same cycle as that B.

## Test plan
- Single fill, addr 0xABCD_1240, data pattern A, all readys 1:
  - fill_ready_o=1 in cycle 0.
  - AW/W valid in cycle 1 with awaddr tag bits 0, wdata valid=1, dirty=1, correct tag, blank=0.
  - B in cycle 3 returns busy_o to 0.
- fill_valid_i and refill_valid_i held together for 4 grants: grant order fill, refill, fill, refill. Refill words carry dirty=0.
- wready_i=0 for 5 cycles with awready_i=1:
  - AW accepted in cycle 1; wvalid stays high with stable wdata.
  - No new grant until W accepted; then S_IDLE.
- MAX_OUTSTANDING=4, bvalid_i held 0:
  - Exactly 4 grants occur, then readys stay 0.
  - One B pulse allows exactly one more grant; a B in the same cycle as a grant keeps outstanding=4.
- bresp_i=2'b10 on the second B: err_o rises the next cycle and stays 1 until rst_n=0.
- rst_n pulsed low while in S_SEND with awready_i=0: next cycle awvalid_o=0, wvalid_o=0, outstanding=0, state S_IDLE.
